// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_if
// Description : Controller <-> datapath bundle for the multicycle ARM-subset
//               core. Carries instruction fields and ALU flags into the
//               controller, and enables and mux selects out to the datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface multicycle_control_if;
    // instruction fields and ALU status, supplied by the datapath
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;

    // enables and mux selects, driven by the controller
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       d_we;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_cntrl;
    logic [3:0] flags;
    logic [3:0] state_o;

    modport master (
        input  cond, op, funct, rd, alu_flags,
        output pc_we, ir_we, rf_we, d_we, adr_src, alu_src_a, alu_src_b,
               result_src, imm_src, reg_src, alu_cntrl, flags, state_o
    );

    modport slave (
        output cond, op, funct, rd, alu_flags,
        input  pc_we, ir_we, rf_we, d_we, adr_src, alu_src_a, alu_src_b,
               result_src, imm_src, reg_src, alu_cntrl, flags, state_o
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control
// Description : Multicycle controller for the ARM-subset core. Sequences the
//               shared ALU, unified memory and register file over 2-5 cycles
//               per instruction, and owns the NZCV register and the
//               condition-check logic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module multicycle_control #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    logic       cond_ex;
    logic       cmd_ok;
    logic [1:0] cmd_ctl;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Condition check against the architectural flags
    always_comb begin
        cond_ex = 1'b0;
        case (bus.cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing cmd to ALU control; unsupported commands become NOPs
    always_comb begin
        cmd_ok  = 1'b1;
        cmd_ctl = 2'b00;
        case (bus.funct[4:1])
            4'b0100: cmd_ctl = 2'b00;
            4'b0010: cmd_ctl = 2'b01;
            4'b0000: cmd_ctl = 2'b10;
            4'b1100: cmd_ctl = 2'b11;
            default: cmd_ok  = 1'b0;
        endcase
    end

    // Per-state datapath controls, next state, and flag/condition updates
    always_comb begin
        state_d        = FETCH;
        flags_d        = flags_q;
        cond_ex_d      = cond_ex_q;
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.rf_we      = 1'b0;
        bus.d_we       = 1'b0;
        bus.adr_src    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.alu_cntrl  = 2'b00;

        case (state_q)
            FETCH: begin
                bus.ir_we      = 1'b1;
                bus.pc_we      = 1'b1;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                state_d        = DECODE;
            end
            DECODE: begin
                // ALU produces PC+8 so an R15 read sees the pipelined value
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                cond_ex_d      = cond_ex;
                case (bus.op)
                    2'b00:   state_d = bus.funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                bus.alu_src_b = 2'b01;
                state_d       = bus.funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.adr_src = 1'b1;
                state_d     = MEMWB;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                bus.rf_we      = cond_ex_q & (bus.rd != 4'd15);
                bus.pc_we      = cond_ex_q & (bus.rd == 4'd15);
            end
            MEMWRITE: begin
                bus.adr_src = 1'b1;
                bus.d_we    = cond_ex_q;
            end
            EXECUTER, EXECUTEI: begin
                bus.alu_src_b = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
                bus.alu_cntrl = cmd_ctl;
                state_d       = ALUWB;
                if (bus.funct[0] && cond_ex_q && cmd_ok) begin
                    flags_d[3:2] = bus.alu_flags[3:2];
                    // logical ops leave carry and overflow untouched
                    if (!cmd_ctl[1])
                        flags_d[1:0] = bus.alu_flags[1:0];
                end
            end
            ALUWB: begin
                bus.rf_we = cond_ex_q & cmd_ok & (bus.rd != 4'd15);
                bus.pc_we = cond_ex_q & cmd_ok & (bus.rd == 4'd15);
            end
            BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_we      = cond_ex_q;
            end
            default: state_d = FETCH;
        endcase

        // an instruction interrupted by reset must not commit anything
        if (reset) begin
            bus.pc_we = 1'b0;
            bus.ir_we = 1'b0;
            bus.rf_we = 1'b0;
            bus.d_we  = 1'b0;
        end
    end

    // State, flag and latched-condition registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            flags_q   <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign bus.imm_src    = bus.op;
    assign bus.reg_src[0] = (bus.op == 2'b10);
    assign bus.reg_src[1] = (bus.op == 2'b01) & ~bus.funct[0];
    assign bus.flags      = flags_q;
    assign bus.state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction is
//               run through an instruction-level reference model that lists
//               the expected per-cycle trace; the DUT trace is compared to it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [3:0]  mflags;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    multicycle_control_if bus ();

    multicycle_control #(.RESET_FLAGS(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Architectural condition check: even codes test a predicate, odd codes its inverse
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cy, v, b;
        {n, z, cy, v} = fl;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (b ^ c[0]);
    endfunction

    // Expected trace: {state, pc_we, ir_we, rf_we, d_we, adr_src, alu_cntrl, reg_src, flags}
    function automatic void model(input logic [3:0] c, input logic [1:0] o,
                                  input logic [5:0] f, input logic [3:0] r,
                                  input logic [3:0] af);
        int         seq[$];
        logic       pass, sup, pc, ir, rf, dw, adr;
        logic [1:0] ctl, alu, rs;
        logic [3:0] st;
        pass = cond_ok(c, mflags);
        sup  = 1'b1;
        case (f[4:1])
            4'd4:    ctl = 2'd0;
            4'd2:    ctl = 2'd1;
            4'd0:    ctl = 2'd2;
            4'd12:   ctl = 2'd3;
            default: begin ctl = 2'd0; sup = 1'b0; end
        endcase
        seq.push_back(0);
        seq.push_back(1);
        case (o)
            2'b00: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (f[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        rs = {(o == 2'b01) & ~f[0], (o == 2'b10)};
        exp_q.delete();
        foreach (seq[i]) begin
            st  = 4'(seq[i]);
            ir  = (st == 0);
            pc  = (st == 0) || (st == 9 && pass) ||
                  (pass && r == 15 && (st == 4 || (st == 8 && sup)));
            rf  = pass && r != 15 && (st == 4 || (st == 8 && sup));
            dw  = (st == 5) && pass;
            adr = (st == 3) || (st == 5);
            alu = (st == 6 || st == 7) ? ctl : 2'd0;
            exp_q.push_back({st, pc, ir, rf, dw, adr, alu, rs, mflags});
            if ((st == 6 || st == 7) && f[0] && pass && sup) begin
                mflags[3:2] = af[3:2];
                if (ctl < 2) mflags[1:0] = af[1:0];
            end
        end
    endfunction

    // Drive one instruction starting in FETCH and record the DUT trace
    task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af);
        model(c, o, f, r, af);
        bus.cond = c; bus.op = o; bus.funct = f; bus.rd = r; bus.alu_flags = af;
        obs_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            obs_q.push_back({bus.state_o, bus.pc_we, bus.ir_we, bus.rf_we, bus.d_we,
                             bus.adr_src, bus.alu_cntrl, bus.reg_src, bus.flags});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.cond = 4'hE; bus.op = 2'b00; bus.funct = 6'b001001; bus.rd = 4'd1;
        bus.alu_flags = 4'hF;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.state_o, bus.flags, bus.pc_we, bus.ir_we, bus.rf_we, bus.d_we} !== 12'h000) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: state/flags/we=%h want 000",
                         k, {bus.state_o, bus.flags, bus.pc_we, bus.ir_we, bus.rf_we, bus.d_we});
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({bus.state_o, bus.ir_we, bus.pc_we} !== 6'b0000_11) begin
            fails++;
            $display("FAIL reset_release: state,ir_we,pc_we=%b want 000011",
                     {bus.state_o, bus.ir_we, bus.pc_we});
        end
        mflags = 4'b0000;
    endtask

    task automatic test_dp();
        logic [3:0] c [4] = '{4'hE, 4'hE, 4'hE, 4'hE};
        logic [5:0] f [4] = '{6'b001001, 6'b101000, 6'b000001, 6'b011010};
        logic [3:0] r [4] = '{4'd1, 4'd15, 4'd2, 4'd3};
        logic [3:0] a [4] = '{4'b0110, 4'b1111, 4'b1001, 4'b0101};
        for (int t = 0; t < 4; t++) begin
            run(c[t], 2'b00, f[t], r[t], a[t]);
            for (int k = 0; k < exp_q.size(); k++) begin
                tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    fails++;
                    $display("FAIL dp[%0d] cyc%0d: got %h want %h", t, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_mem();
        run(4'hE, 2'b01, 6'b011001, 4'd4, 4'h0);
        for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL ldr cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
        run(4'hE, 2'b01, 6'b011000, 4'd5, 4'h0);
        for (int k = 0; k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL str cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] c [3] = '{4'hE, 4'h1, 4'h0};
        logic [1:0] o [3] = '{2'b00, 2'b10, 2'b10};
        logic [5:0] f [3] = '{6'b001001, 6'b000000, 6'b000000};
        for (int t = 0; t < 3; t++) begin
            run(c[t], o[t], f[t], 4'd2, 4'b0100);
            for (int k = 0; k < exp_q.size(); k++) begin
                tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    fails++;
                    $display("FAIL branch[%0d] cyc%0d: got %h want %h", t, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_flags();
        logic [3:0] c [3] = '{4'hE, 4'hE, 4'hB};
        logic [5:0] f [3] = '{6'b001001, 6'b011001, 6'b000101};
        logic [3:0] a [3] = '{4'b0011, 4'b1000, 4'b0100};
        for (int t = 0; t < 3; t++) begin
            run(c[t], 2'b00, f[t], 4'd6, a[t]);
            for (int k = 0; k < exp_q.size(); k++) begin
                tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    fails++;
                    $display("FAIL flags[%0d] cyc%0d: got %h want %h", t, k, obs_q[k], exp_q[k]);
                end
            end
        end
        tests++;
        if (bus.flags !== 4'b1011) begin
            fails++;
            $display("FAIL flags_final: got %b want 1011", bus.flags);
        end
    endtask

    task automatic test_reset_mid();
        bus.cond = 4'hE; bus.op = 2'b01; bus.funct = 6'b011000; bus.rd = 4'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        tests++;
        if ({bus.state_o, bus.d_we} !== 5'b0101_1) begin
            fails++;
            $display("FAIL rmid_pre: state,d_we=%b want 01011", {bus.state_o, bus.d_we});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.pc_we, bus.ir_we, bus.rf_we, bus.d_we} !== 4'b0000) begin
            fails++;
            $display("FAIL rmid_we: we=%b want 0000", {bus.pc_we, bus.ir_we, bus.rf_we, bus.d_we});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests++;
        if ({bus.state_o, bus.flags} !== 8'h00) begin
            fails++;
            $display("FAIL rmid_post: state,flags=%h want 00", {bus.state_o, bus.flags});
        end
        mflags = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] c, r, a;
        logic [1:0] o;
        logic [5:0] f;
        for (int t = 0; t < 80; t++) begin
            c = 4'($urandom_range(0, 15));
            if (t % 3 == 0) c = 4'hE;
            o = 2'($urandom_range(0, 3));
            f = 6'($urandom_range(0, 63));
            r = 4'($urandom_range(0, 15));
            a = 4'($urandom_range(0, 15));
            run(c, o, f, r, a);
            for (int k = 0; k < exp_q.size(); k++) begin
                tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    fails++;
                    $display("FAIL rand[%0d] c=%h o=%0d f=%b rd=%0d cyc%0d: got %h want %h",
                             t, c, o, f, r, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        mflags = 4'b0000;
        test_reset();
        test_dp();
        test_mem();
        test_branch();
        test_flags();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
